// File: rtl/add_sub_unit_pkg.sv
// Shared datapath constants: machine word width, flag-vector layout and
// ALU mode encodings used by the adder/subtractor and its consumers.
package add_sub_unit_pkg;

  localparam int unsigned XLEN = 64;

  localparam int unsigned FLAG_C = 3;
  localparam int unsigned FLAG_V = 2;
  localparam int unsigned FLAG_Z = 1;
  localparam int unsigned FLAG_N = 0;

  localparam logic ALU_ADD = 1'b0;
  localparam logic ALU_SUB = 1'b1;

  typedef logic [3:0] flags_t;

  function automatic flags_t pack_flags(input logic c, input logic v,
                                        input logic z, input logic n);
    flags_t f;
    f         = '0;
    f[FLAG_C] = c;
    f[FLAG_V] = v;
    f[FLAG_Z] = z;
    f[FLAG_N] = n;
    return f;
  endfunction

endpackage

// File: rtl/full_adder.sv
// One-bit full adder cell; chained by add_sub_unit into a ripple-carry adder.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  always_comb begin
    s    = a ^ b ^ cin;
    cout = (a & b) | (cin & (a ^ b));
  end

endmodule

// File: rtl/add_sub_unit.sv
// Two's-complement adder/subtractor with combinational result/flags and a
// one-cycle registered copy for pipelined consumers.
module add_sub_unit
  import add_sub_unit_pkg::*;
#(
  parameter int unsigned WIDTH = XLEN
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             M,
  output logic [WIDTH-1:0] S,
  output logic             C,
  output logic             V,
  output logic             Z,
  output logic             N,
  output logic [WIDTH-1:0] S_q,
  output logic [3:0]       flags_q
);

  logic [WIDTH-1:0] bx;
  logic             cin;
  logic [WIDTH-1:0] sum;
  logic             carry_msb_in;
  logic             carry_out;

  always_comb begin
    cin = (M == ALU_SUB);
    bx  = (M == ALU_ADD) ? B : ~B;
  end

  // Per-stage carry nets keep each link a distinct signal rather than bits
  // of one vector feeding back into itself.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    logic cin_w;
    logic cout_w;
    if (i == 0) begin : g_first
      assign cin_w = cin;
    end else begin : g_chain
      assign cin_w = g_bit[i-1].cout_w;
    end
    full_adder u_fa (
      .a    (A[i]),
      .b    (bx[i]),
      .cin  (cin_w),
      .s    (sum[i]),
      .cout (cout_w)
    );
  end

  assign carry_msb_in = g_bit[WIDTH-1].cin_w;
  assign carry_out    = g_bit[WIDTH-1].cout_w;

  always_comb begin
    S = sum;
    C = carry_out;
    V = carry_out ^ carry_msb_in;
    Z = (sum == '0);
    N = sum[WIDTH-1];
  end

  logic [WIDTH-1:0] res_d, res_q;
  flags_t           flg_d, flg_q;

  always_comb begin
    res_d = S;
    flg_d = pack_flags(C, V, Z, N);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      res_q <= '0;
      flg_q <= '0;
    end else begin
      res_q <= res_d;
      flg_q <= flg_d;
    end
  end

  assign S_q     = res_q;
  assign flags_q = flg_q;

endmodule

// File: tb/tb_add_sub_unit.sv
// Self-checking bench for add_sub_unit: directed corner cases, async reset
// behaviour and randomized operands against an arithmetic reference model.
module tb_add_sub_unit;

  localparam int unsigned W = 64;

  logic         clk;
  logic         rst;
  logic [W-1:0] A, B;
  logic         M;
  logic [W-1:0] S, S_q;
  logic         C, V, Z, N;
  logic [3:0]   flags_q;

  int n_checks;
  int n_fail;

  add_sub_unit #(.WIDTH(W)) dut (
    .clk     (clk),
    .rst     (rst),
    .A       (A),
    .B       (B),
    .M       (M),
    .S       (S),
    .C       (C),
    .V       (V),
    .Z       (Z),
    .N       (N),
    .S_q     (S_q),
    .flags_q (flags_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached (got timeout, required completion)");
    $fatal(1, "watchdog");
  end

  // Reference: plain wide arithmetic, V from the operand/result sign rule.
  logic [W-1:0] exp_s;
  logic [3:0]   exp_f;

  task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic m);
    logic [W:0]   wide;
    logic [W-1:0] bb;
    logic         c, v, z, n;
    bb   = m ? ~b : b;
    wide = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, m};
    c    = wide[W];
    n    = wide[W-1];
    z    = (wide[W-1:0] == '0);
    v    = (a[W-1] == bb[W-1]) && (wide[W-1] != a[W-1]);
    exp_s = wide[W-1:0];
    exp_f = {c, v, z, n};
  endtask

  task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b, input logic m);
    A = a;
    B = b;
    M = m;
    model(a, b, m);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    drive(64'd10, 64'd3, 1'b1);
    #3;
    n_checks++;
    if (S_q !== '0) begin
      n_fail++; $display("FAIL reset_S_q: got %h required %h", S_q, 64'd0);
    end
    n_checks++;
    if (flags_q !== 4'b0000) begin
      n_fail++; $display("FAIL reset_flags_q: got %b required %b", flags_q, 4'b0000);
    end
    n_checks++;
    if (S !== 64'd7) begin
      n_fail++; $display("FAIL reset_S_live: got %h required %h", S, 64'd7);
    end
    @(posedge clk); #1;
    n_checks++;
    if (S_q !== '0) begin
      n_fail++; $display("FAIL reset_hold_S_q: got %h required %h", S_q, 64'd0);
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_pc_plus4();
    @(negedge clk);
    drive(64'd0, 64'd4, 1'b0);
    #1;
    n_checks++;
    if ({S, C, V, Z, N} !== {64'd4, 4'b0000}) begin
      n_fail++; $display("FAIL pc4_comb: got S=%h CVZN=%b required S=%h CVZN=0000", S, {C,V,Z,N}, 64'd4);
    end
    @(posedge clk); #1;
    n_checks++;
    if (S_q !== 64'd4 || flags_q !== 4'b0000) begin
      n_fail++; $display("FAIL pc4_reg: got S_q=%h flags_q=%b required S_q=%h flags_q=0000", S_q, flags_q, 64'd4);
    end
  endtask

  task automatic test_wrap();
    @(negedge clk);
    drive(64'hFFFF_FFFF_FFFF_FFFC, 64'd4, 1'b0);
    #1;
    n_checks++;
    if ({S, C, V, Z, N} !== {64'd0, 4'b1010}) begin
      n_fail++; $display("FAIL wrap_comb: got S=%h CVZN=%b required S=0 CVZN=1010", S, {C,V,Z,N});
    end
    @(posedge clk); #1;
    n_checks++;
    if (S_q !== 64'd0 || flags_q !== 4'b1010) begin
      n_fail++; $display("FAIL wrap_reg: got S_q=%h flags_q=%b required S_q=0 flags_q=1010", S_q, flags_q);
    end
    @(negedge clk);
    drive('1, 64'd1, 1'b0);
    #1;
    n_checks++;
    if ({S, C, Z} !== {64'd0, 1'b1, 1'b1}) begin
      n_fail++; $display("FAIL ones_plus1: got S=%h C=%b Z=%b required S=0 C=1 Z=1", S, C, Z);
    end
  endtask

  task automatic test_sub_borrow();
    @(negedge clk);
    drive(64'd5, 64'd7, 1'b1);
    #1;
    n_checks++;
    if ({S, C, V, Z, N} !== {64'hFFFF_FFFF_FFFF_FFFE, 4'b0001}) begin
      n_fail++; $display("FAIL sub_borrow: got S=%h CVZN=%b required S=fffffffffffffffe CVZN=0001", S, {C,V,Z,N});
    end
    drive(64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, 1'b1);
    #1;
    n_checks++;
    if ({S, C, Z} !== {64'd0, 1'b1, 1'b1}) begin
      n_fail++; $display("FAIL sub_equal: got S=%h C=%b Z=%b required S=0 C=1 Z=1", S, C, Z);
    end
    drive(64'd0, 64'd0, 1'b1);
    #1;
    n_checks++;
    if ({S, C, V, Z, N} !== {64'd0, 4'b1010}) begin
      n_fail++; $display("FAIL sub_zero: got S=%h CVZN=%b required S=0 CVZN=1010", S, {C,V,Z,N});
    end
  endtask

  task automatic test_overflow();
    @(negedge clk);
    drive(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0);
    #1;
    n_checks++;
    if ({S, C, V, Z, N} !== {64'h8000_0000_0000_0000, 4'b0101}) begin
      n_fail++; $display("FAIL ovf_add: got S=%h CVZN=%b required S=8000000000000000 CVZN=0101", S, {C,V,Z,N});
    end
    drive(64'h8000_0000_0000_0000, 64'd1, 1'b1);
    #1;
    n_checks++;
    if ({S, C, V, Z, N} !== {64'h7FFF_FFFF_FFFF_FFFF, 4'b1100}) begin
      n_fail++; $display("FAIL ovf_sub: got S=%h CVZN=%b required S=7fffffffffffffff CVZN=1100", S, {C,V,Z,N});
    end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    drive(64'd0, 64'd4, 1'b0);
    @(posedge clk); #1;
    n_checks++;
    if (S_q !== 64'd4) begin
      n_fail++; $display("FAIL arst_setup: got S_q=%h required %h", S_q, 64'd4);
    end
    @(negedge clk); #2;
    rst = 1'b0;
    #1;
    n_checks++;
    if (S_q !== '0 || flags_q !== 4'b0000) begin
      n_fail++; $display("FAIL arst_clear: got S_q=%h flags_q=%b required S_q=0 flags_q=0000", S_q, flags_q);
    end
    drive(64'd100, 64'd1, 1'b1);
    #1;
    n_checks++;
    if (S !== 64'd99) begin
      n_fail++; $display("FAIL arst_S_live: got %h required %h", S, 64'd99);
    end
    @(posedge clk); #1;
    n_checks++;
    if (S_q !== '0 || flags_q !== 4'b0000) begin
      n_fail++; $display("FAIL arst_hold: got S_q=%h flags_q=%b required S_q=0 flags_q=0000", S_q, flags_q);
    end
    @(negedge clk); #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if (S_q !== '0) begin
      n_fail++; $display("FAIL arst_release_nocap: got S_q=%h required 0", S_q);
    end
    @(posedge clk); #1;
    n_checks++;
    if (S_q !== 64'd99 || flags_q !== 4'b1000) begin
      n_fail++; $display("FAIL arst_first_cap: got S_q=%h flags_q=%b required S_q=%h flags_q=1000", S_q, flags_q, 64'd99);
    end
  endtask

  task automatic test_random();
    logic [W-1:0] a, b;
    logic         m;
    for (int i = 0; i < 10000; i++) begin
      @(negedge clk);
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      case ($urandom_range(0, 7))
        0: b = a;
        1: a = '1;
        2: a = {1'b0, {(W-1){1'b1}}};
        3: b = {1'b1, {(W-1){1'b0}}};
        default: ;
      endcase
      m = $urandom_range(0, 1) == 1;
      drive(a, b, m);
      #1;
      n_checks++;
      if (S !== exp_s || {C, V, Z, N} !== exp_f) begin
        n_fail++;
        $display("FAIL rand_comb[%0d]: A=%h B=%h M=%b got S=%h CVZN=%b required S=%h CVZN=%b",
                 i, a, b, m, S, {C,V,Z,N}, exp_s, exp_f);
      end
      @(posedge clk); #1;
      n_checks++;
      if (S_q !== exp_s || flags_q !== exp_f) begin
        n_fail++;
        $display("FAIL rand_reg[%0d]: got S_q=%h flags_q=%b required S_q=%h flags_q=%b",
                 i, S_q, flags_q, exp_s, exp_f);
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b0;
    A = '0;
    B = '0;
    M = 1'b0;
    test_reset();
    test_pc_plus4();
    test_wrap();
    test_sub_borrow();
    test_overflow();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
